// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: widths, FSM states,
// access size codes and the size-to-byte-length helpers.
package mem_access_ctrl_pkg;

  localparam int unsigned CFG_ADDR_WIDTH = 64;
  localparam int unsigned CFG_DATA_WIDTH = 64;
  localparam int unsigned CFG_INST_WIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IF_REQ,
    S_IF_WAIT,
    S_LD_REQ,
    S_LD_WAIT,
    S_ST,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_t;

  // Number of bytes moved by an access of the given size.
  function automatic logic [7:0] size_len(input size_t sz);
    unique case (sz)
      SZ_B:    return 8'd1;
      SZ_H:    return 8'd2;
      SZ_W:    return 8'd4;
      default: return 8'd8;
    endcase
  endfunction

  // True when the low address bits are not a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] off, input size_t sz);
    unique case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align_ext.sv
// Selects the addressed bytes out of a 64-bit memory word and sign- or
// zero-extends them to 64 bits according to the access size.
module load_align_ext
  import mem_access_ctrl_pkg::*;
(
  input  logic [63:0] i_word,
  input  logic [2:0]  i_offset,
  input  size_t       i_size,
  input  logic        i_unsigned,
  output logic [63:0] o_result
);

  logic [63:0] w_shifted;

  assign w_shifted = i_word >> {i_offset, 3'b000};

  // Extend the low bytes of the shifted word; doubleword passes straight through.
  always_comb begin
    o_result = w_shifted;
    unique case (i_size)
      SZ_B:    o_result = {{56{~i_unsigned & w_shifted[7]}},  w_shifted[7:0]};
      SZ_H:    o_result = {{48{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      SZ_W:    o_result = {{32{~i_unsigned & w_shifted[31]}}, w_shifted[31:0]};
      default: o_result = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Arbitrates instruction fetch and load/store requests onto a single memory
// port with one-cycle read latency. LSU requests win ties with fetch.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = CFG_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = CFG_DATA_WIDTH,
  parameter int unsigned INST_WIDTH = CFG_INST_WIDTH
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iFetchValid,
  input  logic [ADDR_WIDTH-1:0] iFetchAddr,
  output logic                  oFetchReady,
  output logic                  oFetchDone,
  output logic [INST_WIDTH-1:0] oFetchInst,
  input  logic                  iLsuValid,
  input  logic                  iLsuWr,
  input  logic [ADDR_WIDTH-1:0] iLsuAddr,
  input  logic [DATA_WIDTH-1:0] iLsuWrData,
  input  logic [1:0]            iLsuSize,
  input  logic                  iLsuUnsigned,
  output logic                  oLsuReady,
  output logic                  oLsuDone,
  output logic                  oLsuErr,
  output logic [DATA_WIDTH-1:0] oLsuRdData,
  output logic                  oMemRdEn,
  output logic [ADDR_WIDTH-1:0] oMemRdAddrInst,
  output logic [ADDR_WIDTH-1:0] oMemRdAddrLoad,
  output logic                  oMemWrEn,
  output logic [ADDR_WIDTH-1:0] oMemWrAddr,
  output logic [DATA_WIDTH-1:0] oMemWrData,
  output logic [7:0]            oMemWrLen,
  input  logic [INST_WIDTH-1:0] iMemRdDataInst,
  input  logic [DATA_WIDTH-1:0] iMemRdDataLoad
);

  state_t                r_state;
  state_t                w_next;
  logic                  r_is_fetch;
  logic                  r_err;
  logic [2:0]            r_ld_off;
  size_t                 r_ld_size;
  logic                  r_ld_uns;
  logic [ADDR_WIDTH-1:0] r_rd_addr_inst;
  logic [ADDR_WIDTH-1:0] r_rd_addr_load;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [7:0]            r_wr_len;
  logic [INST_WIDTH-1:0] r_fetch_inst;
  logic [DATA_WIDTH-1:0] r_lsu_rd;

  logic                  w_lsu_acc;
  logic                  w_fetch_acc;
  size_t                 w_lsu_size;
  logic                  w_misal;
  logic [DATA_WIDTH-1:0] w_ext;

  assign w_lsu_size  = size_t'(iLsuSize);
  assign w_misal     = is_misaligned(iLsuAddr[2:0], w_lsu_size);
  assign w_lsu_acc   = (r_state == S_IDLE) && iLsuValid;
  assign w_fetch_acc = (r_state == S_IDLE) && iFetchValid && !iLsuValid;

  load_align_ext u_align (
    .i_word     (iMemRdDataLoad),
    .i_offset   (r_ld_off),
    .i_size     (r_ld_size),
    .i_unsigned (r_ld_uns),
    .o_result   (w_ext)
  );

  // State register; reset overrides any pending transition.
  always_ff @(posedge iClock) begin
    if (iReset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Request latching, memory address/data holding and result capture.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_is_fetch     <= 1'b0;
      r_err          <= 1'b0;
      r_ld_off       <= '0;
      r_ld_size      <= SZ_B;
      r_ld_uns       <= 1'b0;
      r_rd_addr_inst <= '0;
      r_rd_addr_load <= '0;
      r_wr_addr      <= '0;
      r_wr_data      <= '0;
      r_wr_len       <= '0;
      r_fetch_inst   <= '0;
      r_lsu_rd       <= '0;
    end else begin
      if (w_fetch_acc) begin
        r_is_fetch     <= 1'b1;
        r_err          <= 1'b0;
        r_rd_addr_inst <= iFetchAddr;
      end
      // Memory-side address/data registers load only for accesses that will
      // actually issue, so they keep their last driven value otherwise.
      if (w_lsu_acc) begin
        r_is_fetch <= 1'b0;
        r_err      <= w_misal;
        r_ld_off   <= iLsuAddr[2:0];
        r_ld_size  <= w_lsu_size;
        r_ld_uns   <= iLsuUnsigned;
        if (!w_misal) begin
          if (iLsuWr) begin
            r_wr_addr <= iLsuAddr;
            r_wr_data <= iLsuWrData;
            r_wr_len  <= size_len(w_lsu_size);
          end else begin
            r_rd_addr_load <= {iLsuAddr[ADDR_WIDTH-1:3], 3'b000};
          end
        end
      end
      if (r_state == S_IF_WAIT) r_fetch_inst <= iMemRdDataInst;
      if (r_state == S_LD_WAIT) r_lsu_rd     <= w_ext;
    end
  end

  // Next-state selection and output decode; every output is forced low in reset.
  always_comb begin
    w_next         = r_state;
    oFetchReady    = 1'b0;
    oLsuReady      = 1'b0;
    oFetchDone     = 1'b0;
    oLsuDone       = 1'b0;
    oLsuErr        = 1'b0;
    oMemRdEn       = 1'b0;
    oMemWrEn       = 1'b0;
    oFetchInst     = '0;
    oLsuRdData     = '0;
    oMemRdAddrInst = '0;
    oMemRdAddrLoad = '0;
    oMemWrAddr     = '0;
    oMemWrData     = '0;
    oMemWrLen      = '0;

    unique case (r_state)
      S_IDLE: begin
        if (w_lsu_acc) begin
          if (w_misal)     w_next = S_RESP;
          else if (iLsuWr) w_next = S_ST;
          else             w_next = S_LD_REQ;
        end else if (w_fetch_acc) begin
          w_next = S_IF_REQ;
        end
      end
      S_IF_REQ:  w_next = S_IF_WAIT;
      S_IF_WAIT: w_next = S_RESP;
      S_LD_REQ:  w_next = S_LD_WAIT;
      S_LD_WAIT: w_next = S_RESP;
      S_ST:      w_next = S_RESP;
      S_RESP:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase

    if (!iReset) begin
      oFetchReady    = (r_state == S_IDLE);
      oLsuReady      = (r_state == S_IDLE);
      oMemRdEn       = (r_state == S_IF_REQ) || (r_state == S_LD_REQ);
      oMemWrEn       = (r_state == S_ST);
      oFetchDone     = (r_state == S_RESP) && r_is_fetch;
      oLsuDone       = (r_state == S_RESP) && !r_is_fetch;
      oLsuErr        = (r_state == S_RESP) && !r_is_fetch && r_err;
      oFetchInst     = r_fetch_inst;
      oLsuRdData     = r_lsu_rd;
      oMemRdAddrInst = r_rd_addr_inst;
      oMemRdAddrLoad = r_rd_addr_load;
      oMemWrAddr     = r_wr_addr;
      oMemWrData     = r_wr_data;
      oMemWrLen      = r_wr_len;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl with a byte-level
// reference model of loads and a one-cycle-latency memory model.
module tb_mem_access_ctrl;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 32;

  logic          iClock = 1'b0;
  logic          iReset;
  logic          iFetchValid;
  logic [AW-1:0] iFetchAddr;
  logic          oFetchReady;
  logic          oFetchDone;
  logic [IW-1:0] oFetchInst;
  logic          iLsuValid;
  logic          iLsuWr;
  logic [AW-1:0] iLsuAddr;
  logic [DW-1:0] iLsuWrData;
  logic [1:0]    iLsuSize;
  logic          iLsuUnsigned;
  logic          oLsuReady;
  logic          oLsuDone;
  logic          oLsuErr;
  logic [DW-1:0] oLsuRdData;
  logic          oMemRdEn;
  logic [AW-1:0] oMemRdAddrInst;
  logic [AW-1:0] oMemRdAddrLoad;
  logic          oMemWrEn;
  logic [AW-1:0] oMemWrAddr;
  logic [DW-1:0] oMemWrData;
  logic [7:0]    oMemWrLen;
  logic [IW-1:0] iMemRdDataInst;
  logic [DW-1:0] iMemRdDataLoad;

  always #5 iClock = ~iClock;

  mem_access_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .INST_WIDTH (IW)
  ) dut (
    .iClock         (iClock),
    .iReset         (iReset),
    .iFetchValid    (iFetchValid),
    .iFetchAddr     (iFetchAddr),
    .oFetchReady    (oFetchReady),
    .oFetchDone     (oFetchDone),
    .oFetchInst     (oFetchInst),
    .iLsuValid      (iLsuValid),
    .iLsuWr         (iLsuWr),
    .iLsuAddr       (iLsuAddr),
    .iLsuWrData     (iLsuWrData),
    .iLsuSize       (iLsuSize),
    .iLsuUnsigned   (iLsuUnsigned),
    .oLsuReady      (oLsuReady),
    .oLsuDone       (oLsuDone),
    .oLsuErr        (oLsuErr),
    .oLsuRdData     (oLsuRdData),
    .oMemRdEn       (oMemRdEn),
    .oMemRdAddrInst (oMemRdAddrInst),
    .oMemRdAddrLoad (oMemRdAddrLoad),
    .oMemWrEn       (oMemWrEn),
    .oMemWrAddr     (oMemWrAddr),
    .oMemWrData     (oMemWrData),
    .oMemWrLen      (oMemWrLen),
    .iMemRdDataInst (iMemRdDataInst),
    .iMemRdDataLoad (iMemRdDataLoad)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Memory contents as pure functions of the address.
  function automatic logic [31:0] inst_fn(input logic [63:0] a);
    if (a == 64'h8000_0004) return 32'h0010_0093;
    return (a[31:0] * 32'h0100_0193) ^ 32'h5bd1_e995 ^ a[63:32];
  endfunction

  function automatic logic [63:0] load_fn(input logic [63:0] a);
    if (a == 64'h8000_0010) return 64'h0000_0000_8000_0000;
    return {a[31:0] * 32'h9E37_79B9, ~a[31:0] ^ 32'h7F4A_7C15 ^ a[63:32]};
  endfunction

  // Expected load result: take the naturally aligned doubleword, pick the
  // addressed bytes, then sign-extend unless unsigned or a full doubleword.
  function automatic logic [63:0] exp_load(input logic [63:0] a, input logic [1:0] sz, input bit uns);
    logic [63:0] dw, v, mask;
    int nbytes;
    nbytes = 1 << sz;
    dw = load_fn(a & ~64'd7);
    v  = dw >> (8 * int'(a[2:0]));
    if (nbytes < 8) begin
      mask = (64'd1 << (8 * nbytes)) - 64'd1;
      v = v & mask;
      if (!uns && v[8 * nbytes - 1]) v = v | ~mask;
    end
    return v;
  endfunction

  // One-cycle-latency read memory: data is only meaningful in the cycle
  // directly after a read enable.
  logic          en_q = 1'b0;
  logic [AW-1:0] ainst_q = '0;
  logic [AW-1:0] aload_q = '0;

  assign iMemRdDataInst = en_q ? inst_fn(ainst_q) : 32'hDEAD_BEEF;
  assign iMemRdDataLoad = en_q ? load_fn(aload_q) : 64'hDEAD_BEEF_DEAD_BEEF;

  int            rd_cnt = 0, wr_cnt = 0, ovl_en = 0, ovl_done = 0;
  int            fdone_cnt = 0, ldone_cnt = 0;
  logic [AW-1:0] mon_rd_inst_a, mon_rd_load_a, mon_wr_a;
  logic [DW-1:0] mon_wr_d;
  logic [7:0]    mon_wr_len;

  // Edge monitor: sees the values that were live during the cycle just ended.
  always @(posedge iClock) begin
    en_q    <= oMemRdEn;
    ainst_q <= oMemRdAddrInst;
    aload_q <= oMemRdAddrLoad;
    if (oMemRdEn) begin
      rd_cnt        <= rd_cnt + 1;
      mon_rd_inst_a <= oMemRdAddrInst;
      mon_rd_load_a <= oMemRdAddrLoad;
    end
    if (oMemWrEn) begin
      wr_cnt     <= wr_cnt + 1;
      mon_wr_a   <= oMemWrAddr;
      mon_wr_d   <= oMemWrData;
      mon_wr_len <= oMemWrLen;
    end
    if (oMemRdEn && oMemWrEn)  ovl_en    <= ovl_en + 1;
    if (oFetchDone && oLsuDone) ovl_done <= ovl_done + 1;
    if (oFetchDone) fdone_cnt <= fdone_cnt + 1;
    if (oLsuDone)   ldone_cnt <= ldone_cnt + 1;
  end

  logic w_any_out;
  assign w_any_out = |{oFetchReady, oFetchDone, oFetchInst, oLsuReady, oLsuDone, oLsuErr,
                       oLsuRdData, oMemRdEn, oMemRdAddrInst, oMemRdAddrLoad, oMemWrEn,
                       oMemWrAddr, oMemWrData, oMemWrLen};

  logic [DW-1:0] exp_rd   = '0;
  logic [IW-1:0] exp_inst = '0;

  // Fetch transaction; called at a negedge with the DUT idle.
  task automatic fetch_op(input logic [63:0] fa);
    int f0, r0, l0, lat;
    f0 = fdone_cnt; r0 = rd_cnt; l0 = ldone_cnt;
    check("f_rdy", oFetchReady, 1);
    iFetchValid = 1'b1;
    iFetchAddr  = fa;
    @(posedge iClock); @(negedge iClock);
    iFetchValid = 1'b0;
    iFetchAddr  = {$urandom, $urandom};
    check("f_busy_rdy", {oFetchReady, oLsuReady}, 0);
    lat = 1;
    while (!oFetchDone && lat < 8) begin
      @(negedge iClock);
      lat++;
    end
    exp_inst = inst_fn(fa);
    check("f_lat", lat, 3);
    check("f_inst", oFetchInst, exp_inst);
    check("f_lsu_done", oLsuDone, 0);
    @(posedge iClock); @(negedge iClock);
    check("f_pulse", fdone_cnt - f0, 1);
    check("f_rd_en", rd_cnt - r0, 1);
    check("f_rd_addr", mon_rd_inst_a, fa);
    check("f_no_ldone", ldone_cnt - l0, 0);
    check("f_inst_hold", oFetchInst, exp_inst);
  endtask

  // LSU transaction; optionally raises a concurrent fetch that must wait.
  task automatic lsu_op(input bit wr, input logic [63:0] a, input logic [63:0] d,
                        input logic [1:0] sz, input bit uns, input bit with_fetch,
                        input logic [63:0] fa);
    int r0, w0, l0, f0, lat, exp_lat;
    logic [63:0] nb;
    bit mis;
    r0 = rd_cnt; w0 = wr_cnt; l0 = ldone_cnt; f0 = fdone_cnt;
    nb  = 64'd1 << sz;
    mis = (a % nb) != 0;
    check("l_rdy", oLsuReady, 1);
    check("l_rdy_f", oFetchReady, 1);
    iLsuValid    = 1'b1;
    iLsuWr       = wr;
    iLsuAddr     = a;
    iLsuWrData   = d;
    iLsuSize     = sz;
    iLsuUnsigned = uns;
    if (with_fetch) begin
      iFetchValid = 1'b1;
      iFetchAddr  = fa;
    end
    @(posedge iClock); @(negedge iClock);
    iLsuValid    = 1'b0;
    iLsuWr       = 1'($urandom);
    iLsuAddr     = {$urandom, $urandom};
    iLsuWrData   = {$urandom, $urandom};
    iLsuSize     = 2'($urandom);
    iLsuUnsigned = 1'($urandom);
    check("l_busy_rdy", {oFetchReady, oLsuReady}, 0);
    lat = 1;
    while (!oLsuDone && lat < 8) begin
      @(negedge iClock);
      if (!oLsuDone) check("l_wait_rdy", {oFetchReady, oLsuReady}, 0);
      lat++;
    end
    exp_lat = mis ? 1 : (wr ? 2 : 3);
    if (!mis && !wr) exp_rd = exp_load(a, sz, uns);
    check("l_lat", lat, exp_lat);
    check("l_err", oLsuErr, mis);
    check("l_rd", oLsuRdData, exp_rd);
    check("l_f_done", oFetchDone, 0);
    @(posedge iClock); @(negedge iClock);
    check("l_pulse", ldone_cnt - l0, 1);
    check("l_no_fdone", fdone_cnt - f0, 0);
    check("l_rd_en", rd_cnt - r0, (!mis && !wr) ? 1 : 0);
    check("l_wr_en", wr_cnt - w0, (!mis && wr) ? 1 : 0);
    check("l_rd_hold", oLsuRdData, exp_rd);
    if (!mis && !wr) check("l_rd_addr", mon_rd_load_a, a & ~64'd7);
    if (!mis && wr) begin
      check("s_addr", mon_wr_a, a);
      check("s_data", mon_wr_d, d);
      check("s_len", mon_wr_len, nb);
    end
    if (with_fetch) fetch_op(fa);
  endtask

  initial begin
    logic [63:0] a, d;
    logic [1:0]  sz;
    int          op;
    int          w0, f0;

    iReset = 1'b1; iFetchValid = 1'b0; iFetchAddr = '0;
    iLsuValid = 1'b0; iLsuWr = 1'b0; iLsuAddr = '0; iLsuWrData = '0;
    iLsuSize = '0; iLsuUnsigned = 1'b0;
    repeat (3) @(posedge iClock);
    @(negedge iClock);
    check("rst_zero", w_any_out, 0);
    iReset = 1'b0;
    @(posedge iClock); @(negedge iClock);
    check("post_rst_rdy", {oFetchReady, oLsuReady}, 2'b11);

    // Directed cases.
    fetch_op(64'h8000_0004);
    check("dir_inst", oFetchInst, 64'h0010_0093);
    lsu_op(1'b0, 64'h8000_0013, '0, 2'd0, 1'b0, 1'b0, '0);
    check("dir_lb", oLsuRdData, 64'hFFFF_FFFF_FFFF_FF80);
    lsu_op(1'b0, 64'h8000_0013, '0, 2'd0, 1'b1, 1'b0, '0);
    check("dir_lbu", oLsuRdData, 64'h80);
    lsu_op(1'b1, 64'h8000_0102, 64'h1234_5678_9ABC_DEF0, 2'd1, 1'b0, 1'b0, '0);
    lsu_op(1'b0, 64'h8000_0003, '0, 2'd2, 1'b0, 1'b1, 64'h8000_0040);

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 3);
      sz = 2'($urandom);
      a  = 64'h8000_0000 + 64'($urandom_range(0, 4095));
      if ($urandom_range(0, 1) == 1) a = a & ~((64'd1 << sz) - 64'd1);
      d  = {$urandom, $urandom};
      case (op)
        0:       fetch_op(64'h8000_0000 + 64'($urandom_range(0, 4095)));
        1:       lsu_op(1'b0, a, d, sz, 1'($urandom), 1'b0, '0);
        2:       lsu_op(1'b1, a, d, sz, 1'($urandom), 1'b0, '0);
        default: lsu_op(1'($urandom), a, d, sz, 1'($urandom), 1'b1,
                        64'h8000_0000 + 64'($urandom_range(0, 4095)));
      endcase
    end

    // Reset during the fetch wait state aborts with no done pulse.
    f0 = fdone_cnt;
    iFetchValid = 1'b1; iFetchAddr = 64'h8000_0200;
    @(posedge iClock); @(negedge iClock);
    iFetchValid = 1'b0;
    @(posedge iClock); @(negedge iClock);
    iReset = 1'b1;
    #1;
    check("rst_if_zero", w_any_out, 0);
    @(posedge iClock); @(negedge iClock);
    check("rst_if_zero2", w_any_out, 0);
    iReset = 1'b0;
    @(posedge iClock); @(negedge iClock);
    check("rst_if_rdy", {oFetchReady, oLsuReady}, 2'b11);
    check("rst_if_nodone", fdone_cnt - f0, 0);
    exp_rd = '0; exp_inst = '0;
    check("rst_if_inst", oFetchInst, exp_inst);
    fetch_op(64'h8000_0300);

    // Reset while in the store state suppresses the write.
    w0 = wr_cnt;
    iLsuValid = 1'b1; iLsuWr = 1'b1; iLsuAddr = 64'h8000_0400;
    iLsuWrData = 64'hCAFE_F00D_1234_5678; iLsuSize = 2'd3; iLsuUnsigned = 1'b0;
    @(posedge iClock); @(negedge iClock);
    iLsuValid = 1'b0;
    iReset = 1'b1;
    #1;
    check("rst_st_wren", oMemWrEn, 0);
    @(posedge iClock); @(negedge iClock);
    iReset = 1'b0;
    @(posedge iClock); @(negedge iClock);
    check("rst_st_nowrite", wr_cnt - w0, 0);
    exp_rd = '0; exp_inst = '0;
    lsu_op(1'b0, 64'h8000_0010, '0, 2'd2, 1'b0, 1'b0, '0);

    check("en_overlap", ovl_en, 0);
    check("done_overlap", ovl_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
